// File: rtl/sensor_pkg.sv
// sensor_pkg
// Constants and types shared by the pixel readout blocks.
//   PIXEL_WIDTH           - bits per pixel sample
//   DEFAULT_ARRAY_WIDTH   - default pixel columns per row
//   DEFAULT_ARRAY_HEIGHT  - default pixel rows
//   readout_state_t       - output-side state of the row readout
package sensor_pkg;

    localparam int PIXEL_WIDTH          = 8;
    localparam int DEFAULT_ARRAY_WIDTH  = 4;
    localparam int DEFAULT_ARRAY_HEIGHT = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,   // no row buffered, pix_valid low
        ST_STREAM = 1'b1    // head row is being streamed out
    } readout_state_t;

endpackage

// File: rtl/row_fifo.sv
// row_fifo
// Two-entry FIFO holding whole captured rows. The head entry is read
// combinationally so a row pushed in one cycle is visible the next.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   push        - write push_data (caller guarantees not full, or pop)
//   push_data   - entry to store
//   pop         - drop the head entry (caller guarantees not empty)
//   head_data   - oldest stored entry
//   count       - number of stored entries (0..2)
//   full        - both entries occupied
module row_fifo #(
    parameter int ENTRY_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [ENTRY_WIDTH-1:0] push_data,
    input  logic                   pop,
    output logic [ENTRY_WIDTH-1:0] head_data,
    output logic [1:0]             count,
    output logic                   full
);

    logic [ENTRY_WIDTH-1:0] mem [2];
    logic                   wr_ptr_reg;
    logic                   rd_ptr_reg;
    logic [1:0]             count_reg;

    // Storage carries no reset; head_data is only consumed when count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;
    assign full      = (count_reg == 2'd2);

endmodule

// File: rtl/row_readout.sv
// row_readout
// Buffers converted pixel rows in a 2-entry FIFO and streams them out one
// pixel per cycle with valid/ready handshaking and row/column/eol/eof tags.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   row_select   - one-hot row read select (pixel array READ bus)
//   row_capture  - strobe: conversion of the selected row complete
//   data_in      - pixel array DATA_OUT bus, column 0 in element 0
//   pix_data     - current pixel value
//   pix_valid    - pix_data and tags valid
//   pix_ready    - consumer accepts the pixel
//   pix_row      - row index of the pixel
//   pix_col      - column index of the pixel
//   pix_eol      - last column of a row
//   pix_eof      - last column of the last row
//   overflow     - sticky: a row was dropped because the FIFO was full
//   sel_err      - sticky: capture seen with a non-one-hot row_select
module row_readout
    import sensor_pkg::*;
#(
    parameter int PIXEL_ARRAY_WIDTH  = DEFAULT_ARRAY_WIDTH,
    parameter int PIXEL_ARRAY_HEIGHT = DEFAULT_ARRAY_HEIGHT
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [PIXEL_ARRAY_HEIGHT-1:0]                   row_select,
    input  logic                                            row_capture,
    input  logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_WIDTH-1:0]   data_in,
    output logic [PIXEL_WIDTH-1:0]                          pix_data,
    output logic                                            pix_valid,
    input  logic                                            pix_ready,
    output logic [$clog2(PIXEL_ARRAY_HEIGHT)-1:0]           pix_row,
    output logic [$clog2(PIXEL_ARRAY_WIDTH)-1:0]            pix_col,
    output logic                                            pix_eol,
    output logic                                            pix_eof,
    output logic                                            overflow,
    output logic                                            sel_err
);

    localparam int ROW_W   = $clog2(PIXEL_ARRAY_HEIGHT);
    localparam int COL_W   = $clog2(PIXEL_ARRAY_WIDTH);
    localparam int DATA_W  = PIXEL_ARRAY_WIDTH * PIXEL_WIDTH;
    localparam int ENTRY_W = DATA_W + ROW_W;

    readout_state_t state_reg, state_next;
    logic [COL_W-1:0] col_reg, col_next;
    logic             overflow_reg;
    logic             sel_err_reg;

    // Row select decoding
    logic [ROW_W-1:0] sel_terms [PIXEL_ARRAY_HEIGHT];
    logic [ROW_W-1:0] sel_index;
    logic             sel_onehot;

    // Each set bit contributes its own index; OR-reduction yields the
    // encoded index, which is only meaningful when exactly one bit is set.
    generate
        for (genvar gi = 0; gi < PIXEL_ARRAY_HEIGHT; gi++) begin : g_sel_enc
            assign sel_terms[gi] = row_select[gi] ? ROW_W'(gi) : '0;
        end
    endgenerate

    always_comb begin
        sel_index = '0;
        for (int i = 0; i < PIXEL_ARRAY_HEIGHT; i++) begin
            sel_index = sel_index | sel_terms[i];
        end
    end

    assign sel_onehot = (row_select != '0) &&
                        ((row_select & (row_select - PIXEL_ARRAY_HEIGHT'(1))) == '0);

    // FIFO
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [1:0]         fifo_count;
    logic [1:0]         count_next;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               transfer;
    logic               capture_ok;
    logic               col_last;

    logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_WIDTH-1:0] head_pixels;
    logic [ROW_W-1:0]                              head_row;

    assign push_entry = {sel_index, data_in};
    assign {head_row, head_pixels} = head_entry;

    row_fifo #(
        .ENTRY_WIDTH (ENTRY_W)
    ) u_row_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    // Handshake and FIFO control. A full FIFO still accepts a capture when
    // the head row is popped in the same cycle.
    assign col_last   = (col_reg == COL_W'(PIXEL_ARRAY_WIDTH - 1));
    assign transfer   = pix_valid && pix_ready;
    assign pop        = transfer && col_last;
    assign capture_ok = row_capture && sel_onehot;
    assign push       = capture_ok && (!fifo_full || pop) && !reset;
    assign count_next = fifo_count + {1'b0, push} - {1'b0, pop};

    always_comb begin
        col_next = col_reg;
        if (transfer) begin
            col_next = col_last ? '0 : col_reg + COL_W'(1);
        end
    end

    // Next state and outputs
    always_comb begin
        state_next = ST_IDLE;
        if (count_next != 2'd0) begin
            state_next = ST_STREAM;
        end

        pix_valid = 1'b0;
        pix_data  = '0;
        pix_row   = '0;
        pix_eol   = 1'b0;
        pix_eof   = 1'b0;
        case (state_reg)
            ST_STREAM: begin
                pix_valid = 1'b1;
                pix_data  = head_pixels[col_reg];
                pix_row   = head_row;
                pix_eol   = col_last;
                pix_eof   = col_last && (head_row == ROW_W'(PIXEL_ARRAY_HEIGHT - 1));
            end
            default: ;
        endcase
    end

    assign pix_col  = col_reg;
    assign overflow = overflow_reg;
    assign sel_err  = sel_err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            col_reg      <= '0;
            overflow_reg <= 1'b0;
            sel_err_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            if (capture_ok && fifo_full && !pop) begin
                overflow_reg <= 1'b1;
            end
            if (row_capture && !sel_onehot) begin
                sel_err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_row_readout.sv
module tb_row_readout;

    localparam int W = 4;
    localparam int H = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [H-1:0]         row_select;
    logic                 row_capture;
    logic [W-1:0][7:0]    data_in;
    logic [7:0]           pix_data;
    logic                 pix_valid;
    logic                 pix_ready;
    logic [1:0]           pix_row;
    logic [1:0]           pix_col;
    logic                 pix_eol;
    logic                 pix_eof;
    logic                 overflow;
    logic                 sel_err;

    always #5 clk = ~clk;

    row_readout #(
        .PIXEL_ARRAY_WIDTH  (W),
        .PIXEL_ARRAY_HEIGHT (H)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .row_select  (row_select),
        .row_capture (row_capture),
        .data_in     (data_in),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_row     (pix_row),
        .pix_col     (pix_col),
        .pix_eol     (pix_eol),
        .pix_eof     (pix_eof),
        .overflow    (overflow),
        .sel_err     (sel_err)
    );

    // Reference model: a queue of whole rows and the number of pixels of the
    // head row already delivered.
    typedef struct {
        logic [W-1:0][7:0] pix;
        int                row;
    } row_t;

    row_t q[$];
    int   m_sent;
    bit   m_ovf;
    bit   m_serr;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pixels = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare outputs against the model, then advance one clock.
    task automatic cycle();
        bit        v;
        bit        last;
        bit        xfer;
        logic [7:0] e_data;
        int        e_row;
        v      = (q.size() != 0);
        last   = v && (m_sent == W - 1);
        e_data = v ? q[0].pix[m_sent] : 8'h00;
        e_row  = v ? q[0].row : 0;
        check("pix_valid", 32'(pix_valid), 32'(v));
        check("pix_data",  32'(pix_data),  32'(e_data));
        check("pix_row",   32'(pix_row),   32'(e_row));
        check("pix_col",   32'(pix_col),   32'(m_sent));
        check("pix_eol",   32'(pix_eol),   32'(last));
        check("pix_eof",   32'(pix_eof),   32'(last && e_row == H - 1));
        check("overflow",  32'(overflow),  32'(m_ovf));
        check("sel_err",   32'(sel_err),   32'(m_serr));

        xfer = v && pix_ready && !reset;
        if (xfer) begin
            n_pixels++;
            $display("pixel row=%0d col=%0d data=%02h eol=%0b eof=%0b",
                     pix_row, pix_col, pix_data, pix_eol, pix_eof);
        end

        if (reset) begin
            q.delete();
            m_sent = 0;
            m_ovf  = 0;
            m_serr = 0;
        end else begin
            if (xfer) begin
                if (m_sent == W - 1) begin
                    void'(q.pop_front());
                    m_sent = 0;
                end else begin
                    m_sent++;
                end
            end
            if (row_capture) begin
                if ($countones(row_select) != 1) begin
                    m_serr = 1;
                end else if (q.size() < 2) begin
                    row_t r;
                    r.pix = data_in;
                    r.row = 0;
                    for (int i = 0; i < H; i++) if (row_select[i]) r.row = i;
                    q.push_back(r);
                end else begin
                    m_ovf = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [H-1:0] sel, input logic [31:0] d);
        row_select  = sel;
        row_capture = 1'b1;
        data_in     = d;
        cycle();
        row_capture = 1'b0;
        data_in     = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        row_select  = '0;
        row_capture = 1'b0;
        data_in     = '0;
        pix_ready   = 1'b0;
        m_sent = 0;
        m_ovf  = 0;
        m_serr = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // Basic row 1, ready high: 11,22,33,44 with eol on 44
        pix_ready = 1'b1;
        capture(4'b0010, 32'h44332211);
        check("first_pixel_const", 32'(pix_data), 32'h11);
        check("first_row_const",   32'(pix_row),  32'd1);
        idle(3);
        check("eol_on_44_const", 32'({pix_eol, pix_data}), 32'h144);
        idle(2);

        // Stalls mid-row
        pix_ready = 1'b1;
        capture(4'b0100, 32'hA4A3A2A1);
        pix_ready = 1'b0;
        idle(2);
        pix_ready = 1'b1;
        idle(5);

        // Three captures while stalled: third dropped
        pix_ready = 1'b0;
        capture(4'b0001, 32'h0D0C0B0A);
        capture(4'b1000, 32'h1D1C1B1A);
        capture(4'b0100, 32'h2D2C2B2A);
        idle(2);
        check("overflow_const", 32'(overflow), 32'd1);
        pix_ready = 1'b1;
        idle(10);

        // Full FIFO, capture coincides with last-column transfer
        do_reset();
        pix_ready = 1'b0;
        capture(4'b0001, 32'h03020100);
        capture(4'b0010, 32'h13121110);
        pix_ready = 1'b1;
        idle(3);
        capture(4'b0100, 32'h23222120);
        check("no_overflow_const", 32'(overflow), 32'd0);
        idle(10);

        // Non-one-hot selects
        capture(4'b0000, 32'hDEADBEEF);
        capture(4'b0110, 32'hCAFEF00D);
        idle(2);
        check("sel_err_const", 32'(sel_err), 32'd1);

        // Reset mid-row, then row 3 again with eof
        do_reset();
        capture(4'b1000, 32'h37363534);
        idle(2);
        reset       = 1'b1;
        row_select  = 4'b0001;
        row_capture = 1'b1;   // reset must win over this capture
        cycle();
        reset       = 1'b0;
        row_capture = 1'b0;
        idle(1);
        capture(4'b1000, 32'h47464544);
        idle(3);
        check("eof_const", 32'({pix_eof, pix_col}), 32'h7);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            pix_ready   = ($urandom_range(0, 9) < 7);
            row_capture = ($urandom_range(0, 3) == 0);
            row_select  = ($urandom_range(0, 9) < 8) ? H'(1 << $urandom_range(0, H - 1))
                                                     : H'($urandom_range(0, 15));
            data_in     = $urandom;
            reset       = ($urandom_range(0, 149) == 0);
            cycle();
        end
        reset       = 1'b0;
        row_capture = 1'b0;
        pix_ready   = 1'b1;
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
